cnn_result_reader: RTL and testbench
====================================

Name: cnn_result_reader

Overview:
- Consumer end of the simpleCNN classifier output interface: the hardware counterpart of the bench that samples result, count, prob_0..prob_9 and fc_done.
- On each fc_done rising edge it captures all ten class scores and re-derives the winning class with a sequential signed argmax.
- It checks the derived class against the network's own result, then presents a record to a downstream logger with a valid/ready handshake.

Parameters:
- PROB_W, 113, width of each signed class score.
- CNT_W, 16, width of the count tag and of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- fc_done  in  1  classifier-done level from the CNN; may stay high for several cycles.
- result  in  4  class index reported by the CNN.
- count  in  CNT_W  image/cycle tag from the CNN.
- prob_0 .. prob_9  in  PROB_W each  signed class scores.
- out_valid  out  1  output record valid.
- out_ready  in  1  downstream accept.
- out_class  out  4  recomputed argmax index, 0..9.
- out_score  out  PROB_W  signed maximum score.
- out_count  out  CNT_W  captured count tag.
- out_mismatch  out  1  out_class differs from the captured result.
- out_margin  out  PROB_W+1  max minus second-best score (see Optional Feature).
- busy  out  1  state is not IDLE.
- overrun  out  1  sticky: a fc_done edge was dropped.
- img_cnt  out  CNT_W  records delivered; wraps.
- err_cnt  out  CNT_W  delivered records with mismatch; saturates at all-ones.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE.
  - Capture registers 0.
  - fc_done edge-detect register 0.
- Edge detect: done_edge = fc_done & ~fc_done_q. fc_done_q is registered every cycle.
- IDLE:
  - On done_edge in cycle N, register prob_0..9, result and count.
  - best_idx=0, best=prob_0.
  - Go to SCAN with i=1.
- SCAN, one class per cycle, i = 1..9:
  - If cap[i] > best (signed, strict), then best=cap[i] and best_idx=i.
  - Ties keep the lower index.
  - After i=9, go to PRESENT.
  - SCAN occupies cycles N+1..N+9.
- PRESENT:
  - out_valid rises at N+10.
  - out_* are stable while out_valid=1 and out_ready=0.
  - Transfer happens in a cycle with out_valid & out_ready.
  - On transfer: out_valid falls next cycle; img_cnt+1; err_cnt+1 if out_mismatch; state returns to IDLE.
  - out_ready held high gives a minimum inter-record spacing of 11 cycles.
- out_mismatch = (best_idx != captured result). It is valid whenever out_valid=1.
- A result > 9 always mismatches.
- done_edge while busy (SCAN or PRESENT):
  - The new event is dropped.
  - overrun is set and stays set until reset.
  - The in-flight record is unaffected.
- done_edge in the same cycle as a PRESENT transfer is also dropped and sets overrun. Capture happens only from IDLE.
- fc_done held high produces exactly one capture.
- Asynchronous reset mid-SCAN or mid-PRESENT:
  - Returns immediately to IDLE with all outputs 0.
  - The pending record is discarded.
  - Counters are cleared.
- img_cnt wraps from all-ones to 0. err_cnt saturates.
- out_* other than out_valid hold the last record after transfer until the next capture completes.

Optional Feature:
- Macro: CNN_RESULT_MARGIN_EN.
- Defined:
  - SCAN also tracks second-best.
  - When a new max is found, the old best becomes second; else if cap[i] > second, then second=cap[i].
  - second starts at prob_1 ordered against prob_0 at capture, so the scan begins at i=2.
  - Latency is unchanged: i=1 is an idle compare slot.
  - out_margin = best - second, sign-extended to PROB_W+1. It is always >= 0.
- Not defined: out_margin is tied to 0 and no second-best logic is built.

Test Plan:
- Scores prob_k = k*100 (prob_9 = 900), result=9, count=42, edge at cycle N:
  - out_valid at N+10.
  - out_class=9, out_score=900, out_count=42, out_mismatch=0.
  - With CNN_RESULT_MARGIN_EN: out_margin=100.
- Scores all -5 except prob_3=prob_7=-1, result=7:
  - out_class=3 (tie to lower index), out_score=-1, out_mismatch=1.
  - err_cnt increments to 1 on transfer.
- out_ready=0 for 20 cycles after out_valid:
  - out_* stay stable.
  - A second fc_done edge at +5 sets overrun=1.
  - After out_ready=1, img_cnt=1 and busy=0 next cycle.
- fc_done held high 30 cycles with out_ready=1:
  - Exactly one record is delivered.
  - img_cnt=1, overrun=0.
- rst pulsed at SCAN cycle 4:
  - All outputs 0 at once.
  - No out_valid afterwards.
  - A fresh fc_done edge is then processed normally with 10-cycle latency.
- 3 back-to-back images spaced 11 cycles, out_ready=1:
  - img_cnt=3, overrun=0.
  - One fc_done edge at spacing 10 sets overrun.

Source files
------------

// File: rtl/cnn_result_reader_if.sv
// cnn_result_reader_if: classifier-output and logger-record signals between the CNN side (master)
// and the result reader (slave).
interface cnn_result_reader_if #(
  parameter int PROB_W = 113,
  parameter int CNT_W = 16
);
  logic fc_done;
  logic [3:0] result;
  logic [CNT_W-1:0] count;
  logic signed [PROB_W-1:0] prob_0, prob_1, prob_2, prob_3, prob_4;
  logic signed [PROB_W-1:0] prob_5, prob_6, prob_7, prob_8, prob_9;
  logic out_valid;
  logic out_ready;
  logic [3:0] out_class;
  logic signed [PROB_W-1:0] out_score;
  logic [CNT_W-1:0] out_count;
  logic out_mismatch;
  logic signed [PROB_W:0] out_margin;
  logic busy;
  logic overrun;
  logic [CNT_W-1:0] img_cnt;
  logic [CNT_W-1:0] err_cnt;
  modport master (
    output fc_done, result, count, out_ready,
    output prob_0, prob_1, prob_2, prob_3, prob_4, prob_5, prob_6, prob_7, prob_8, prob_9,
    input out_valid, out_class, out_score, out_count, out_mismatch, out_margin,
    input busy, overrun, img_cnt, err_cnt
  );
  modport slave (
    input fc_done, result, count, out_ready,
    input prob_0, prob_1, prob_2, prob_3, prob_4, prob_5, prob_6, prob_7, prob_8, prob_9,
    output out_valid, out_class, out_score, out_count, out_mismatch, out_margin,
    output busy, overrun, img_cnt, err_cnt
  );
endinterface

// File: rtl/cnn_result_reader.sv
// cnn_result_reader: captures the ten class scores on each fc_done edge, re-derives the signed argmax
// one class per cycle, flags disagreement with the CNN result and hands the record to a logger.
// Optional CNN_RESULT_MARGIN_EN also tracks the second-best score and reports best minus second.
module cnn_result_reader #(
  parameter int PROB_W = 113,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  cnn_result_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;
  state_t state, state_d;
  logic fc_done_q, done_edge, xfer, take, capture, last;
  logic signed [PROB_W-1:0] prob [10];
  logic signed [PROB_W-1:0] cap [10];
  logic signed [PROB_W-1:0] best, best_n, cur, init_best;
  logic [3:0] idx, best_idx, idx_n, init_idx, cap_result;
  logic [CNT_W-1:0] cap_count;
  assign prob = '{bus.prob_0, bus.prob_1, bus.prob_2, bus.prob_3, bus.prob_4,
                  bus.prob_5, bus.prob_6, bus.prob_7, bus.prob_8, bus.prob_9};
  assign done_edge = bus.fc_done & ~fc_done_q;
  assign xfer = bus.out_valid & bus.out_ready;
  assign capture = state == IDLE && done_edge;
  assign last = state == SCAN && idx == 4'd9;
  assign bus.busy = state != IDLE;
  assign cur = cap[idx];
  assign best_n = take ? cur : best;
  assign idx_n = take ? idx : best_idx;
`ifdef CNN_RESULT_MARGIN_EN
  logic signed [PROB_W-1:0] second, second_n;
  logic step, p1_hi;
  // classes 0 and 1 are ordered at capture, so the i=1 scan slot only keeps latency fixed
  assign step = idx != 4'd1;
  assign p1_hi = prob[1] > prob[0];
  assign take = step && cur > best;
  assign second_n = take ? best : (step && cur > second) ? cur : second;
  assign init_best = p1_hi ? prob[1] : prob[0];
  assign init_idx = {3'd0, p1_hi};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      second <= '0;
      bus.out_margin <= '0;
    end else begin
      if (capture) second <= p1_hi ? prob[0] : prob[1];
      else if (state == SCAN) second <= second_n;
      if (last) bus.out_margin <= {best_n[PROB_W-1], best_n} - {second_n[PROB_W-1], second_n};
    end
`else
  assign take = cur > best;
  assign init_best = prob[0];
  assign init_idx = '0;
  assign bus.out_margin = '0;
`endif
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (done_edge ? SCAN : IDLE) :
              state == SCAN ? (idx == 4'd9 ? PRESENT : SCAN) :
              (xfer ? IDLE : PRESENT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fc_done_q <= 1'b0;
      cap <= '{default: '0};
      cap_result <= '0;
      cap_count <= '0;
      idx <= '0;
      best <= '0;
      best_idx <= '0;
      bus.out_valid <= 1'b0;
      bus.out_class <= '0;
      bus.out_score <= '0;
      bus.out_count <= '0;
      bus.out_mismatch <= 1'b0;
      bus.overrun <= 1'b0;
      bus.img_cnt <= '0;
      bus.err_cnt <= '0;
    end else begin
      fc_done_q <= bus.fc_done;
      if (capture) begin
        cap <= prob;
        cap_result <= bus.result;
        cap_count <= bus.count;
        idx <= 4'd1;
        best <= init_best;
        best_idx <= init_idx;
      end else if (state == SCAN) begin
        idx <= last ? idx : idx + 4'd1;
        best <= best_n;
        best_idx <= idx_n;
      end
      if (last) begin
        bus.out_valid <= 1'b1;
        bus.out_class <= idx_n;
        bus.out_score <= best_n;
        bus.out_count <= cap_count;
        bus.out_mismatch <= idx_n != cap_result;
      end else if (xfer) bus.out_valid <= 1'b0;
      if (xfer) begin
        bus.img_cnt <= bus.img_cnt + CNT_W'(1);
        if (bus.out_mismatch && !(&bus.err_cnt)) bus.err_cnt <= bus.err_cnt + CNT_W'(1);
      end
      // edges seen outside IDLE, including the transfer cycle, are lost
      if (done_edge && state != IDLE) bus.overrun <= 1'b1;
    end
endmodule

// File: tb/tb_cnn_result_reader.sv
// tb_cnn_result_reader: directed vectors against hand-computed records, handshake, overrun and reset cases.
module tb_cnn_result_reader;
  localparam int PROB_W = 113;
  localparam int CNT_W = 16;
`ifdef CNN_RESULT_MARGIN_EN
  localparam int MARGIN_ON = 1;
`else
  localparam int MARGIN_ON = 0;
`endif
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int lat, recs, seen;
  int v_up [10] = '{0, 100, 200, 300, 400, 500, 600, 700, 800, 900};
  int v_tie [10] = '{-5, -5, -5, -1, -5, -5, -5, -1, -5, -5};
  int v_dn [10] = '{50, 40, 30, 20, 10, 0, -10, -20, -30, -40};
  int v_zero [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  cnn_result_reader_if #(.PROB_W(PROB_W), .CNT_W(CNT_W)) bus ();
  cnn_result_reader #(.PROB_W(PROB_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [127:0] got, input logic signed [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_img(input int p [10], input logic [3:0] res, input logic [CNT_W-1:0] cnt);
    bus.prob_0 = PROB_W'(p[0]); bus.prob_1 = PROB_W'(p[1]); bus.prob_2 = PROB_W'(p[2]);
    bus.prob_3 = PROB_W'(p[3]); bus.prob_4 = PROB_W'(p[4]); bus.prob_5 = PROB_W'(p[5]);
    bus.prob_6 = PROB_W'(p[6]); bus.prob_7 = PROB_W'(p[7]); bus.prob_8 = PROB_W'(p[8]);
    bus.prob_9 = PROB_W'(p[9]);
    bus.result = res;
    bus.count = cnt;
  endtask
  task automatic pulse_gap(input int gap);
    bus.fc_done = 1'b1;
    @(negedge clk);
    bus.fc_done = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    bus.fc_done = 1'b0;
    bus.out_ready = 1'b0;
    set_img(v_zero, 4'd0, 16'd0);
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_img", bus.img_cnt, 0);
    chk("rst_margin", bus.out_margin, 0);
    rst = 1'b0;
    set_img(v_up, 4'd9, 16'd42);
    pulse_gap(1);
    wait_valid(lat);
    chk("up_lat", lat, 10);
    chk("up_class", bus.out_class, 9);
    chk("up_score", bus.out_score, 900);
    chk("up_count", bus.out_count, 42);
    chk("up_mis", bus.out_mismatch, 0);
    chk("up_margin", bus.out_margin, MARGIN_ON ? 100 : 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("up_xfer_valid", bus.out_valid, 0);
    chk("up_xfer_img", bus.img_cnt, 1);
    chk("up_xfer_busy", bus.busy, 0);
    set_img(v_tie, 4'd7, 16'd5);
    pulse_gap(1);
    wait_valid(lat);
    chk("tie_lat", lat, 10);
    chk("tie_class", bus.out_class, 3);
    chk("tie_score", bus.out_score, -1);
    chk("tie_mis", bus.out_mismatch, 1);
    chk("tie_margin", bus.out_margin, 0);
    repeat (4) @(negedge clk);
    set_img(v_zero, 4'd0, 16'd99);
    pulse_gap(1);
    repeat (14) @(negedge clk);
    chk("stall_valid", bus.out_valid, 1);
    chk("stall_class", bus.out_class, 3);
    chk("stall_score", bus.out_score, -1);
    chk("stall_count", bus.out_count, 5);
    chk("stall_overrun", bus.overrun, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stall_img", bus.img_cnt, 2);
    chk("stall_err", bus.err_cnt, 1);
    chk("stall_busy", bus.busy, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= int'(bus.out_valid);
    end
    chk("dropped_no_rec", seen, 0);
    set_img(v_up, 4'd9, 16'd42);
    pulse_gap(1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_class", bus.out_class, 0);
    chk("arst_score", bus.out_score, 0);
    chk("arst_count", bus.out_count, 0);
    chk("arst_mis", bus.out_mismatch, 0);
    chk("arst_img", bus.img_cnt, 0);
    chk("arst_err", bus.err_cnt, 0);
    chk("arst_overrun", bus.overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen |= int'(bus.out_valid);
    end
    chk("arst_no_rec", seen, 0);
    pulse_gap(1);
    wait_valid(lat);
    chk("fresh_lat", lat, 10);
    chk("fresh_class", bus.out_class, 9);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("fresh_img", bus.img_cnt, 1);
    set_img(v_dn, 4'd0, 16'd7);
    bus.fc_done = 1'b1;
    recs = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) recs++;
    end
    bus.fc_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_recs", recs, 1);
    chk("hold_img", bus.img_cnt, 2);
    chk("hold_overrun", bus.overrun, 0);
    chk("hold_class", bus.out_class, 0);
    chk("hold_score", bus.out_score, 50);
    chk("hold_count", bus.out_count, 7);
    chk("hold_margin", bus.out_margin, MARGIN_ON ? 10 : 0);
    set_img(v_up, 4'd9, 16'd42);
    repeat (3) pulse_gap(11);
    chk("b2b_img", bus.img_cnt, 5);
    chk("b2b_overrun", bus.overrun, 0);
    chk("b2b_err", bus.err_cnt, 0);
    set_img(v_up, 4'd12, 16'd43);
    pulse_gap(10);
    pulse_gap(15);
    chk("gap10_overrun", bus.overrun, 1);
    chk("gap10_img", bus.img_cnt, 6);
    chk("bigres_mis", bus.out_mismatch, 1);
    chk("bigres_err", bus.err_cnt, 1);
    chk("gap10_count", bus.out_count, 43);
    chk("gap10_valid", bus.out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
